// File: rtl/ovi_mem_port.sv
// Memory-side endpoint for the OVI load/store petition channel: in-order request
// FIFO feeding a req/gnt SRAM port, with registered load-data return.
module ovi_mem_port #(
  parameter int REQ_DEPTH = 4,
  parameter int MAX_OUTST = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                PET_LOAD_VALID,
  input  logic                PET_STORE_VALID,
  input  logic [ADDR_W-1:0]   PET_ADDR,
  input  logic [DATA_W-1:0]   PET_STORE_DATA,
  input  logic [DATA_W/8-1:0] PET_STORE_BYEN,
  output logic                RSP_MEM_READY,
  output logic                RSP_LOAD_VALID,
  output logic [DATA_W-1:0]   RSP_LOAD_DATA,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [ADDR_W-1:0]   MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_WDATA,
  output logic [DATA_W/8-1:0] MEM_BE,
  input  logic                MEM_GNT,
  input  logic                MEM_RVALID,
  input  logic [DATA_W-1:0]   MEM_RDATA,
  output logic                BUSY,
  output logic [1:0]          ERR
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(REQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OST_W = 3;

  logic [ADDR_W-1:0] q_addr [REQ_DEPTH];
  logic [DATA_W-1:0] q_data [REQ_DEPTH];
  logic [BE_W-1:0]   q_be   [REQ_DEPTH];
  logic              q_we   [REQ_DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    free_cnt;
  logic [OST_W-1:0]  outst, outst_next;
  logic              empty, full;
  logic              push_any, push_ok, pop, both_pet, misalign;
  logic              rd_gnt, rd_ret;
  logic [ADDR_W-1:0] push_addr;
  logic [BE_W-1:0]   push_be;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;
  logic [1:0]        err;

  // A simultaneous load+store keeps only the store; loads carry all-ones enables.
  assign both_pet  = PET_LOAD_VALID && PET_STORE_VALID;
  assign push_any  = PET_LOAD_VALID || PET_STORE_VALID;
  assign misalign  = push_any && (PET_ADDR[2:0] != 3'b000);
  assign push_addr = {PET_ADDR[ADDR_W-1:3], 3'b000};
  assign push_be   = PET_STORE_VALID ? PET_STORE_BYEN : {BE_W{1'b1}};

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(REQ_DEPTH));

  // A return in this cycle frees its slot for a read issued in the same cycle.
  assign rd_ret     = MEM_RVALID && (outst != '0);
  assign outst_next = outst - OST_W'(rd_ret);

  assign MEM_REQ = !empty && (q_we[rd_ptr] || (outst_next < OST_W'(MAX_OUTST)));
  assign pop     = MEM_REQ && MEM_GNT;
  assign rd_gnt  = pop && !q_we[rd_ptr];
  assign push_ok = push_any && (!full || pop);

  assign MEM_WE    = !empty && q_we[rd_ptr];
  assign MEM_ADDR  = empty ? '0 : q_addr[rd_ptr];
  assign MEM_WDATA = empty ? '0 : q_data[rd_ptr];
  assign MEM_BE    = empty ? '0 : q_be[rd_ptr];

  // One slot of slack absorbs the petition already in flight when ready drops.
  assign free_cnt      = (CNT_W+1)'(REQ_DEPTH) - {1'b0, count};
  assign RSP_MEM_READY = free_cnt >= ((CNT_W+1)'(2) + (CNT_W+1)'(push_any));

  assign RSP_LOAD_VALID = vld_p1;
  assign RSP_LOAD_DATA  = rdata_p1;
  assign BUSY           = !empty || (outst != '0);
  assign ERR            = err;

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      q_addr[wr_ptr] <= push_addr;
      q_data[wr_ptr] <= PET_STORE_DATA;
      q_be[wr_ptr]   <= push_be;
      q_we[wr_ptr]   <= PET_STORE_VALID;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      outst  <= '0;
      err    <= 2'b00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case ({rd_gnt, rd_ret})
        2'b10:   outst <= outst + OST_W'(1);
        2'b01:   outst <= outst - OST_W'(1);
        default: outst <= outst;
      endcase
      err[0] <= err[0] | misalign;
      err[1] <= err[1] | both_pet | (push_any && full && !pop);
    end
  end

  // Stage p1: registered load return
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_ret;
      if (rd_ret) rdata_p1 <= MEM_RDATA;
    end
  end

endmodule
